spatz_vrf_rr: RTL and testbench
===============================

Name: spatz_vrf_rr

Overview:
Parametrised, banked vector register file for Spatz. It replaces fixed-priority port-to-bank mapping with per-bank round-robin arbitration over any number of read and write ports. Each port uses a req/gnt handshake; read data is registered. It sits between the VFU/VLSU/VSLDU operand and result paths and flop-based bank storage.

Parameters:
NR_VREGS, 32, number of architectural vector registers (power of 2)
VLEN, 512, bits per vector register
WORD_W, 64, bits per bank access word (N_IPU*ELEN)
NR_BANKS, 4, number of banks (power of 2, >=1)
NR_READ_PORTS, 5, requesting read ports
NR_WRITE_PORTS, 3, requesting write ports
NR_RD_PER_BANK, 2, physical read ports per bank

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
waddr_i  in  NR_WRITE_PORTS*AddrW  word address {vreg, word index}
wdata_i  in  NR_WRITE_PORTS*WORD_W  write data
wbe_i  in  NR_WRITE_PORTS*WORD_W/8  byte enables (see optional feature)
wreq_i  in  NR_WRITE_PORTS  write request
wgnt_o  out  NR_WRITE_PORTS  write accepted this cycle
raddr_i  in  NR_READ_PORTS*AddrW  read word address
rreq_i  in  NR_READ_PORTS  read request
rgnt_o  out  NR_READ_PORTS  read accepted this cycle
rdata_o  out  NR_READ_PORTS*WORD_W  read data, valid when rvalid_o
rvalid_o  out  NR_READ_PORTS  rdata valid, 1 cycle after rgnt

Behaviour:
- WordsPerReg = VLEN/WORD_W. AddrW = log2(NR_VREGS)+log2(WordsPerReg). Bank = word index [log2(NR_BANKS)-1:0]. Row = {vreg, remaining word-index bits}. Depth/bank = NR_VREGS*WordsPerReg/NR_BANKS.
- Write: each bank has 1 write port. Among wreq_i targeting a bank, a round-robin arbiter grants exactly one. wgnt_o is combinational in the same cycle. Storage updates at the next rising edge. Ungranted requesters hold req/addr/data stable until granted.
- Read: each bank has NR_RD_PER_BANK physical ports. Round-robin grants up to NR_RD_PER_BANK requesters per cycle. rdata_o/rvalid_o are registered: valid exactly one cycle after rgnt_o. rdata_o holds its last value when rvalid_o=0.
- RR pointer, per bank and per direction: after any grant, the pointer moves to one past the highest-index port granted that cycle. It does not move when there is no grant. A sole requester is always granted.
- Same-cycle read and write of the same word: the read returns the old data (read-before-write); no forwarding.
- A granted write is visible to a read granted in the following cycle.
- Different banks operate fully in parallel. Requests to different rows of one bank serialise.
- Reset (async, rst_i=1): all storage 0, RR pointers 0, rvalid_o=0, rdata_o=0. gnt outputs are 0 while in reset. Reset mid-operation drops in-flight reads; no rvalid is issued after reset deasserts.
- Request with an out-of-range vreg: cannot occur for power-of-2 parameters. Assert parameter legality at elaboration (NR_RD_PER_BANK>=1, VLEN%(WORD_W*NR_BANKS)==0).

Optional Feature:
SPATZ_VRF_RR_WBE_EN:
- Defined: wbe_i gates writes per byte; only enabled bytes update.
- Undefined: wbe_i is ignored and every granted write updates the full word. Storage needs no byte-lane enables.

Decomposition:
- spatz_pkg: vrf_addr_t, vrf_word_t, vrf_be_t derived from NR_VREGS/VLEN/WORD_W.
- One sub-module: spatz_vrf_rr_bank. It holds the storage, the per-bank write RR arbiter, and an N-grant read RR arbiter. The top level does address decode, the per-port gnt OR-reduction, and the rdata output registers/mux.

Test Plan:
- Reset, then read all 4 banks at vreg 0 -> rvalid one cycle after gnt, rdata=0.
- Write port 0 to addr 0x09 (vreg1, word1, bank1) with 0xDEADBEEF_CAFEF00D; next cycle read port 2 at 0x09 -> rdata_o[2]=0xDEADBEEF_CAFEF00D two cycles after the write request.
- Write ports 0,1,2 all hold requests to bank 0 (addrs 0x00/0x04/0x08) for 3 cycles -> grants in order 0,1,2, one per cycle; a repeat burst starts at port 0 again.
- 5 read ports all request bank 2 -> cycle 1 grants {0,1}, cycle 2 grants {2,3}, cycle 3 grants {4}; each rvalid arrives 1 cycle after its grant.
- Same-cycle write 0x55.. and read of addr 0x1F -> read returns the prior value; a read in the next cycle returns 0x55...
- With SPATZ_VRF_RR_WBE_EN: write 0xFF..FF, then write 0x0 with wbe=0x0F -> read 0xFFFFFFFF_00000000; without the macro -> read 0x0.

Source files
------------

// File: rtl/spatz_vrf_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spatz_vrf_rr_pkg
// Purpose  : Default geometry, word/address types and helpers for the
//            round-robin banked vector register file.
// Revision : 1.0 - initial release
// ============================================================================
package spatz_vrf_rr_pkg;

  localparam int unsigned c_nr_vregs      = 32;
  localparam int unsigned c_vlen          = 512;
  localparam int unsigned c_word_w        = 64;
  localparam int unsigned c_nr_banks      = 4;
  localparam int unsigned c_words_per_reg = c_vlen / c_word_w;
  localparam int unsigned c_addr_w        = $clog2(c_nr_vregs) + $clog2(c_words_per_reg);

  typedef logic [c_addr_w-1:0]   vrf_addr_t;
  typedef logic [c_word_w-1:0]   vrf_word_t;
  typedef logic [c_word_w/8-1:0] vrf_be_t;

  // Index width that stays at least 1 bit for single-entry selections.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spatz_vrf_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : spatz_vrf_rr_if
// Purpose  : Read/write port bundle of the banked VRF (req/gnt handshakes).
// Revision : 1.0 - initial release
// ============================================================================
interface spatz_vrf_rr_if #(
  parameter int unsigned NR_READ_PORTS  = 5,
  parameter int unsigned NR_WRITE_PORTS = 3,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned WORD_W         = 64
);

  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]   waddr_i;
  logic [NR_WRITE_PORTS-1:0][WORD_W-1:0]   wdata_i;
  logic [NR_WRITE_PORTS-1:0][WORD_W/8-1:0] wbe_i;
  logic [NR_WRITE_PORTS-1:0]               wreq_i;
  logic [NR_WRITE_PORTS-1:0]               wgnt_o;
  logic [NR_READ_PORTS-1:0][ADDR_W-1:0]    raddr_i;
  logic [NR_READ_PORTS-1:0]                rreq_i;
  logic [NR_READ_PORTS-1:0]                rgnt_o;
  logic [NR_READ_PORTS-1:0][WORD_W-1:0]    rdata_o;
  logic [NR_READ_PORTS-1:0]                rvalid_o;

  modport master (
    output waddr_i, wdata_i, wbe_i, wreq_i, raddr_i, rreq_i,
    input  wgnt_o, rgnt_o, rdata_o, rvalid_o
  );

  modport slave (
    input  waddr_i, wdata_i, wbe_i, wreq_i, raddr_i, rreq_i,
    output wgnt_o, rgnt_o, rdata_o, rvalid_o
  );

endinterface
`default_nettype wire

// File: rtl/spatz_vrf_rr_bank.sv
`default_nettype none
// ============================================================================
// Module   : spatz_vrf_rr_bank
// Purpose  : One VRF bank: flop storage, 1-grant write RR arbiter and
//            N-grant read RR arbiter. Byte enables honoured only when
//            SPATZ_VRF_RR_WBE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spatz_vrf_rr_bank
  import spatz_vrf_rr_pkg::*;
#(
  parameter int unsigned NR_READ_PORTS  = 5,
  parameter int unsigned NR_WRITE_PORTS = 3,
  parameter int unsigned NR_RD_PER_BANK = 2,
  parameter int unsigned ROW_W          = 6,
  parameter int unsigned WORD_W         = 64
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [NR_WRITE_PORTS-1:0]                          wreq_i,
  input  logic [NR_WRITE_PORTS-1:0][ROW_W-1:0]               wrow_i,
  input  logic [NR_WRITE_PORTS-1:0][WORD_W-1:0]              wdata_i,
  input  logic [NR_WRITE_PORTS-1:0][WORD_W/8-1:0]            wbe_i,
  output logic [NR_WRITE_PORTS-1:0]                          wgnt_o,
  input  logic [NR_READ_PORTS-1:0]                           rreq_i,
  input  logic [NR_READ_PORTS-1:0][ROW_W-1:0]                rrow_i,
  output logic [NR_READ_PORTS-1:0]                           rgnt_o,
  output logic [NR_RD_PER_BANK-1:0]                          slot_vld_o,
  output logic [NR_RD_PER_BANK-1:0][idx_w(NR_READ_PORTS)-1:0] slot_port_o,
  output logic [NR_RD_PER_BANK-1:0][WORD_W-1:0]              slot_data_o
);

  localparam int unsigned c_wp_w  = idx_w(NR_WRITE_PORTS);
  localparam int unsigned c_rp_w  = idx_w(NR_READ_PORTS);
  localparam int unsigned c_depth = 1 << ROW_W;

  logic [WORD_W-1:0]                           r_mem [c_depth];
  logic [c_wp_w-1:0]                           r_wptr;
  logic [c_rp_w-1:0]                           r_rptr;
  logic                                        w_wany;
  logic [c_wp_w-1:0]                           w_wsel;
  logic [NR_WRITE_PORTS-1:0]                   w_wgnt;
  logic [NR_READ_PORTS-1:0]                    w_rgnt;
  logic [c_rp_w-1:0]                           w_rhi;
  logic [NR_RD_PER_BANK-1:0]                   w_slot_vld;
  logic [NR_RD_PER_BANK-1:0][c_rp_w-1:0]       w_slot_port;

  always_comb begin
    int unsigned idx;
    idx    = 0;
    w_wany = 1'b0;
    w_wsel = '0;
    w_wgnt = '0;
    for (int unsigned i = 0; i < NR_WRITE_PORTS; i++) begin
      idx = 32'(r_wptr) + i;
      if (idx >= NR_WRITE_PORTS) idx = idx - NR_WRITE_PORTS;
      if (!w_wany && wreq_i[idx[c_wp_w-1:0]]) begin
        w_wany = 1'b1;
        w_wsel = idx[c_wp_w-1:0];
      end
    end
    if (rst_i) w_wany = 1'b0;
    if (w_wany) w_wgnt[w_wsel] = 1'b1;
  end

  // Scan from the pointer and take the first NR_RD_PER_BANK requesters.
  always_comb begin
    int unsigned idx;
    int unsigned cnt;
    idx    = 0;
    cnt    = 0;
    w_rgnt = '0;
    for (int unsigned i = 0; i < NR_READ_PORTS; i++) begin
      idx = 32'(r_rptr) + i;
      if (idx >= NR_READ_PORTS) idx = idx - NR_READ_PORTS;
      if (rreq_i[idx[c_rp_w-1:0]] && (cnt < NR_RD_PER_BANK)) begin
        w_rgnt[idx[c_rp_w-1:0]] = 1'b1;
        cnt = cnt + 1;
      end
    end
    if (rst_i) w_rgnt = '0;
  end

  // Pack grants onto physical read slots in ascending port order.
  always_comb begin
    logic placed;
    placed      = 1'b0;
    w_slot_vld  = '0;
    w_slot_port = '0;
    w_rhi       = '0;
    for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
      placed = 1'b0;
      if (w_rgnt[p]) begin
        w_rhi = c_rp_w'(p);
        for (int unsigned k = 0; k < NR_RD_PER_BANK; k++) begin
          if (!placed && !w_slot_vld[k]) begin
            w_slot_vld[k]  = 1'b1;
            w_slot_port[k] = c_rp_w'(p);
            placed         = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wany)
        r_wptr <= (w_wsel == c_wp_w'(NR_WRITE_PORTS - 1)) ? '0 : w_wsel + 1'b1;
      if (|w_rgnt)
        r_rptr <= (w_rhi == c_rp_w'(NR_READ_PORTS - 1)) ? '0 : w_rhi + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < c_depth; r++) r_mem[r] <= '0;
    end else if (w_wany) begin
`ifdef SPATZ_VRF_RR_WBE_EN
      for (int unsigned b = 0; b < WORD_W / 8; b++) begin
        if (wbe_i[w_wsel][b])
          r_mem[wrow_i[w_wsel]][8*b +: 8] <= wdata_i[w_wsel][8*b +: 8];
      end
`else
      r_mem[wrow_i[w_wsel]] <= wdata_i[w_wsel];
`endif
    end
  end

`ifndef SPATZ_VRF_RR_WBE_EN
  logic w_unused_wbe;
  assign w_unused_wbe = ^wbe_i;
`endif

  for (genvar k = 0; k < NR_RD_PER_BANK; k++) begin : g_slot
    assign slot_data_o[k] = r_mem[rrow_i[w_slot_port[k]]];
  end

  assign wgnt_o      = w_wgnt;
  assign rgnt_o      = w_rgnt;
  assign slot_vld_o  = w_slot_vld;
  assign slot_port_o = w_slot_port;

endmodule
`default_nettype wire

// File: rtl/spatz_vrf_rr.sv
`default_nettype none
// ============================================================================
// Module   : spatz_vrf_rr
// Purpose  : Banked VRF with per-bank round-robin arbitration over any number
//            of read/write ports; registered read data. Optional macro
//            SPATZ_VRF_RR_WBE_EN enables per-byte write enables.
// Revision : 1.0 - initial release
// ============================================================================
module spatz_vrf_rr
  import spatz_vrf_rr_pkg::*;
#(
  parameter int unsigned NR_VREGS       = c_nr_vregs,
  parameter int unsigned VLEN           = c_vlen,
  parameter int unsigned WORD_W         = c_word_w,
  parameter int unsigned NR_BANKS       = c_nr_banks,
  parameter int unsigned NR_READ_PORTS  = 5,
  parameter int unsigned NR_WRITE_PORTS = 3,
  parameter int unsigned NR_RD_PER_BANK = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spatz_vrf_rr_if.slave  vrf
);

  localparam int unsigned c_reg_words  = VLEN / WORD_W;
  localparam int unsigned c_addr_bits  = $clog2(NR_VREGS) + $clog2(c_reg_words);
  localparam int unsigned c_bank_w     = $clog2(NR_BANKS);
  localparam int unsigned c_bank_idx_w = idx_w(NR_BANKS);
  localparam int unsigned c_row_w      = c_addr_bits - c_bank_w;
  localparam int unsigned c_rp_w       = idx_w(NR_READ_PORTS);

  if (NR_RD_PER_BANK < 1) begin : g_chk_rd_ports
    $error("spatz_vrf_rr: NR_RD_PER_BANK must be at least 1");
  end
  if ((VLEN % (WORD_W * NR_BANKS)) != 0) begin : g_chk_vlen
    $error("spatz_vrf_rr: VLEN must be a multiple of WORD_W*NR_BANKS");
  end
  if ((NR_BANKS & (NR_BANKS - 1)) != 0 || (NR_VREGS & (NR_VREGS - 1)) != 0) begin : g_chk_pow2
    $error("spatz_vrf_rr: NR_BANKS and NR_VREGS must be powers of two");
  end

  logic [NR_WRITE_PORTS-1:0][c_bank_idx_w-1:0]           w_wbank;
  logic [NR_WRITE_PORTS-1:0][c_row_w-1:0]                w_wrow;
  logic [NR_READ_PORTS-1:0][c_bank_idx_w-1:0]            w_rbank;
  logic [NR_READ_PORTS-1:0][c_row_w-1:0]                 w_rrow;
  logic [NR_BANKS-1:0][NR_WRITE_PORTS-1:0]               w_bank_wgnt;
  logic [NR_BANKS-1:0][NR_READ_PORTS-1:0]                w_bank_rgnt;
  logic [NR_BANKS-1:0][NR_RD_PER_BANK-1:0]               w_slot_vld;
  logic [NR_BANKS-1:0][NR_RD_PER_BANK-1:0][c_rp_w-1:0]   w_slot_port;
  logic [NR_BANKS-1:0][NR_RD_PER_BANK-1:0][WORD_W-1:0]   w_slot_data;
  logic [NR_WRITE_PORTS-1:0]                             w_wgnt;
  logic [NR_READ_PORTS-1:0]                              w_rgnt;
  logic [NR_READ_PORTS-1:0][WORD_W-1:0]                  w_rnext;
  logic [NR_READ_PORTS-1:0]                              r_rvalid;
  logic [NR_READ_PORTS-1:0][WORD_W-1:0]                  r_rdata;

  // Bank is the low word-index bits; the rest of the address is the row.
  for (genvar p = 0; p < NR_WRITE_PORTS; p++) begin : g_wdec
    if (NR_BANKS > 1) begin : g_multi
      assign w_wbank[p] = vrf.waddr_i[p][c_bank_w-1:0];
      assign w_wrow[p]  = vrf.waddr_i[p][c_addr_bits-1:c_bank_w];
    end else begin : g_single
      assign w_wbank[p] = '0;
      assign w_wrow[p]  = vrf.waddr_i[p];
    end
  end

  for (genvar p = 0; p < NR_READ_PORTS; p++) begin : g_rdec
    if (NR_BANKS > 1) begin : g_multi
      assign w_rbank[p] = vrf.raddr_i[p][c_bank_w-1:0];
      assign w_rrow[p]  = vrf.raddr_i[p][c_addr_bits-1:c_bank_w];
    end else begin : g_single
      assign w_rbank[p] = '0;
      assign w_rrow[p]  = vrf.raddr_i[p];
    end
  end

  for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
    logic [NR_WRITE_PORTS-1:0] w_wreq;
    logic [NR_READ_PORTS-1:0]  w_rreq;

    for (genvar p = 0; p < NR_WRITE_PORTS; p++) begin : g_wreq
      assign w_wreq[p] = vrf.wreq_i[p] & (w_wbank[p] == c_bank_idx_w'(b));
    end
    for (genvar p = 0; p < NR_READ_PORTS; p++) begin : g_rreq
      assign w_rreq[p] = vrf.rreq_i[p] & (w_rbank[p] == c_bank_idx_w'(b));
    end

    spatz_vrf_rr_bank #(
      .NR_READ_PORTS  (NR_READ_PORTS),
      .NR_WRITE_PORTS (NR_WRITE_PORTS),
      .NR_RD_PER_BANK (NR_RD_PER_BANK),
      .ROW_W          (c_row_w),
      .WORD_W         (WORD_W)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wreq_i      (w_wreq),
      .wrow_i      (w_wrow),
      .wdata_i     (vrf.wdata_i),
      .wbe_i       (vrf.wbe_i),
      .wgnt_o      (w_bank_wgnt[b]),
      .rreq_i      (w_rreq),
      .rrow_i      (w_rrow),
      .rgnt_o      (w_bank_rgnt[b]),
      .slot_vld_o  (w_slot_vld[b]),
      .slot_port_o (w_slot_port[b]),
      .slot_data_o (w_slot_data[b])
    );
  end

  // A port targets exactly one bank, so OR-merging bank results is exact.
  always_comb begin
    w_wgnt  = '0;
    w_rgnt  = '0;
    w_rnext = '0;
    for (int unsigned b = 0; b < NR_BANKS; b++) begin
      w_wgnt = w_wgnt | w_bank_wgnt[b];
      w_rgnt = w_rgnt | w_bank_rgnt[b];
      for (int unsigned k = 0; k < NR_RD_PER_BANK; k++) begin
        if (w_slot_vld[b][k]) w_rnext[w_slot_port[b][k]] = w_slot_data[b][k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rgnt;
      for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
        if (w_rgnt[p]) r_rdata[p] <= w_rnext[p];
      end
    end
  end

  assign vrf.wgnt_o   = w_wgnt;
  assign vrf.rgnt_o   = w_rgnt;
  assign vrf.rvalid_o = r_rvalid;
  assign vrf.rdata_o  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spatz_vrf_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_spatz_vrf_rr
// Purpose  : Directed bench for spatz_vrf_rr with an address-level reference
//            model compared every cycle plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spatz_vrf_rr;
  import spatz_vrf_rr_pkg::*;

  localparam int NR   = 5;
  localparam int NW   = 3;
  localparam int NB   = 4;
  localparam int NRPB = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  spatz_vrf_rr_if #(
    .NR_READ_PORTS  (NR),
    .NR_WRITE_PORTS (NW),
    .ADDR_W         (c_addr_w),
    .WORD_W         (c_word_w)
  ) vrf ();

  spatz_vrf_rr #(
    .NR_VREGS       (c_nr_vregs),
    .VLEN           (c_vlen),
    .WORD_W         (c_word_w),
    .NR_BANKS       (NB),
    .NR_READ_PORTS  (NR),
    .NR_WRITE_PORTS (NW),
    .NR_RD_PER_BANK (NRPB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .vrf   (vrf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: flat word-addressed memory plus per-bank RR pointers.
  vrf_word_t              m_mem [256];
  int                     m_wptr [NB];
  int                     m_rptr [NB];
  logic [NR-1:0]          m_rvalid;
  logic [NR-1:0][63:0]    m_rdata;

  always @(negedge clk) begin : model
    logic [NW-1:0] e_wg;
    logic [NR-1:0] e_rg;
    int  p, n, hi, a;
    bit  done;
    if (rst) begin
      check("rst_wgnt", vrf.wgnt_o, '0);
      check("rst_rgnt", vrf.rgnt_o, '0);
      check("rst_rvalid", vrf.rvalid_o, '0);
      check("rst_rdata", vrf.rdata_o, '0);
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
      for (int b = 0; b < NB; b++) begin m_wptr[b] = 0; m_rptr[b] = 0; end
      m_rvalid = '0;
      m_rdata  = '0;
    end else begin
      e_wg = '0;
      e_rg = '0;
      for (int b = 0; b < NB; b++) begin
        done = 1'b0;
        for (int k = 0; k < NW; k++) begin
          p = (m_wptr[b] + k) % NW;
          if (!done && vrf.wreq_i[p] && (int'(vrf.waddr_i[p]) % NB) == b) begin
            e_wg[p] = 1'b1;
            done    = 1'b1;
          end
        end
        for (int q = 0; q < NW; q++) if (e_wg[q] && (int'(vrf.waddr_i[q]) % NB) == b) m_wptr[b] = (q + 1) % NW;
        n  = 0;
        hi = -1;
        for (int k = 0; k < NR; k++) begin
          p = (m_rptr[b] + k) % NR;
          if (n < NRPB && vrf.rreq_i[p] && (int'(vrf.raddr_i[p]) % NB) == b) begin
            e_rg[p] = 1'b1;
            n++;
            if (p > hi) hi = p;
          end
        end
        if (hi >= 0) m_rptr[b] = (hi + 1) % NR;
      end
      check("wgnt", vrf.wgnt_o, e_wg);
      check("rgnt", vrf.rgnt_o, e_rg);
      check("rvalid", vrf.rvalid_o, m_rvalid);
      check("rdata", vrf.rdata_o, m_rdata);
      for (int q = 0; q < NR; q++) if (e_rg[q]) m_rdata[q] = m_mem[int'(vrf.raddr_i[q])];
      m_rvalid = e_rg;
      for (int q = 0; q < NW; q++) begin
        if (e_wg[q]) begin
          a = int'(vrf.waddr_i[q]);
`ifdef SPATZ_VRF_RR_WBE_EN
          for (int by = 0; by < 8; by++)
            if (vrf.wbe_i[q][by]) m_mem[a][8*by +: 8] = vrf.wdata_i[q][8*by +: 8];
`else
          m_mem[a] = vrf.wdata_i[q];
`endif
        end
      end
    end
  end

  task automatic step(output logic [NW-1:0] wg, output logic [NR-1:0] rg);
    @(negedge clk);
    wg = vrf.wgnt_o;
    rg = vrf.rgnt_o;
    @(posedge clk);
    #1;
  endtask

  logic [NW-1:0] wg;
  logic [NR-1:0] rg;
  logic [NW-1:0] wseq [3];
  logic [NR-1:0] rseq [3];
  vrf_word_t     wbe_exp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    vrf.waddr_i = '0; vrf.wdata_i = '0; vrf.wbe_i = '1; vrf.wreq_i = '0;
    vrf.raddr_i = '0; vrf.rreq_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rvalid", vrf.rvalid_o, '0);
    check("reset_rdata", vrf.rdata_o, '0);

    // One read per bank at vreg 0 (port 4 takes bank 2).
    vrf.raddr_i[0] = 8'h00; vrf.raddr_i[1] = 8'h01;
    vrf.raddr_i[4] = 8'h02; vrf.raddr_i[3] = 8'h03;
    vrf.rreq_i = 5'b11011;
    step(wg, rg);
    vrf.rreq_i = '0;
    check("t1_rgnt", rg, 5'b11011);
    check("t1_rvalid", vrf.rvalid_o, 5'b11011);
    check("t1_rdata0", vrf.rdata_o[0], 64'h0);
    check("t1_rdata4", vrf.rdata_o[4], 64'h0);

    // Write then read back through another port.
    vrf.waddr_i[0] = 8'h09; vrf.wdata_i[0] = 64'hDEADBEEF_CAFEF00D; vrf.wreq_i = 3'b001;
    step(wg, rg);
    vrf.wreq_i = '0;
    check("t2_wgnt", wg, 3'b001);
    vrf.raddr_i[2] = 8'h09; vrf.rreq_i = 5'b00100;
    step(wg, rg);
    vrf.rreq_i = '0;
    check("t2_rgnt", rg, 5'b00100);
    check("t2_rvalid", vrf.rvalid_o, 5'b00100);
    check("t2_rdata", vrf.rdata_o[2], 64'hDEADBEEF_CAFEF00D);

    // Three writers contend for bank 0, twice.
    for (int rep = 0; rep < 2; rep++) begin
      vrf.waddr_i[0] = 8'h00; vrf.waddr_i[1] = 8'h04; vrf.waddr_i[2] = 8'h08;
      for (int p = 0; p < NW; p++) vrf.wdata_i[p] = 64'h1000 * (rep + 1) + 64'(p);
      vrf.wreq_i = 3'b111;
      for (int c = 0; c < 3; c++) begin
        step(wg, rg);
        wseq[c] = wg;
        vrf.wreq_i = vrf.wreq_i & ~wg;
      end
      check("wburst_c0", wseq[0], 3'b001);
      check("wburst_c1", wseq[1], 3'b010);
      check("wburst_c2", wseq[2], 3'b100);
      vrf.wreq_i = '0;
    end

    // Five readers contend for bank 2.
    vrf.raddr_i[0] = 8'h02; vrf.raddr_i[1] = 8'h06; vrf.raddr_i[2] = 8'h0A;
    vrf.raddr_i[3] = 8'h0E; vrf.raddr_i[4] = 8'h12;
    vrf.rreq_i = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      step(wg, rg);
      rseq[c] = rg;
      check("rburst_rvalid", vrf.rvalid_o, rg);
      vrf.rreq_i = vrf.rreq_i & ~rg;
    end
    vrf.rreq_i = '0;
    check("rburst_c0", rseq[0], 5'b00011);
    check("rburst_c1", rseq[1], 5'b01100);
    check("rburst_c2", rseq[2], 5'b10000);

    // Read-before-write on the same word.
    vrf.waddr_i[0] = 8'h1F; vrf.wdata_i[0] = 64'h01234567_89ABCDEF; vrf.wreq_i = 3'b001;
    step(wg, rg);
    vrf.waddr_i[1] = 8'h1F; vrf.wdata_i[1] = 64'h55555555_55555555; vrf.wreq_i = 3'b010;
    vrf.raddr_i[3] = 8'h1F; vrf.rreq_i = 5'b01000;
    step(wg, rg);
    vrf.wreq_i = '0;
    check("rbw_old", vrf.rdata_o[3], 64'h01234567_89ABCDEF);
    step(wg, rg);
    vrf.rreq_i = '0;
    check("rbw_new", vrf.rdata_o[3], 64'h55555555_55555555);

    // Bank 3 read pointer sits at 4: grants {4,0}, then wraps to pick 1.
    vrf.raddr_i[0] = 8'h03; vrf.raddr_i[1] = 8'h07; vrf.raddr_i[4] = 8'h0B;
    vrf.rreq_i = 5'b10011;
    step(wg, rg);
    check("wrap_c0", rg, 5'b10001);
    vrf.rreq_i = vrf.rreq_i & ~rg;
    step(wg, rg);
    check("wrap_c1", rg, 5'b00010);
    vrf.rreq_i = '0;

    // Byte-enable behaviour.
    vrf.waddr_i[2] = 8'h0D; vrf.wdata_i[2] = '1; vrf.wbe_i[2] = 8'hFF; vrf.wreq_i = 3'b100;
    step(wg, rg);
    vrf.wdata_i[2] = '0; vrf.wbe_i[2] = 8'h0F;
    step(wg, rg);
    vrf.wreq_i = '0; vrf.wbe_i[2] = 8'hFF;
    vrf.raddr_i[0] = 8'h0D; vrf.rreq_i = 5'b00001;
    step(wg, rg);
    vrf.rreq_i = '0;
`ifdef SPATZ_VRF_RR_WBE_EN
    wbe_exp = 64'hFFFFFFFF_00000000;
`else
    wbe_exp = 64'h0;
`endif
    check("wbe_rdata", vrf.rdata_o[0], wbe_exp);

    // Reset between a grant and its rvalid.
    vrf.raddr_i[1] = 8'h0D; vrf.rreq_i = 5'b00010;
    @(negedge clk);
    rg = vrf.rgnt_o;
    #1 rst = 1'b1;
    vrf.rreq_i = '0;
    check("midrst_gnt", rg, 5'b00010);
    @(posedge clk);
    #1;
    check("midrst_rvalid", vrf.rvalid_o, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(wg, rg);
    check("postrst_rvalid", vrf.rvalid_o, '0);
    vrf.raddr_i[2] = 8'h09; vrf.rreq_i = 5'b00100;
    step(wg, rg);
    vrf.rreq_i = '0;
    check("postrst_rvalid2", vrf.rvalid_o, 5'b00100);
    check("postrst_rdata", vrf.rdata_o[2], 64'h0);

    repeat (2) step(wg, rg);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
